// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed access latency, byte-enabled stores and sign/zero-extended loads
module dmem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        RdValid,
    output logic        Stall,
    output logic        MisalignErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            wr_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            rdv_q, rdv_d;
    logic            mis_q, mis_d;
    logic [31:0]     mem [DEPTH];

    logic            req;
    logic [2:0]      cur_f3;
    logic [AW+1:0]   cur_addr;
    logic [31:0]     cur_wdata;
    logic            cur_wr;
    logic [AW-1:0]   cur_idx;
    logic            misaligned;
    logic            enter_done;
    logic            mem_we;
    logic [3:0]      byte_en;
    logic [31:0]     wr_lanes;
    logic [31:0]     word;
    logic [31:0]     shifted;
    logic [31:0]     load_val;
    logic            unused_addr;

    assign unused_addr = ^Addr[31:AW+2];
    assign req         = MemRead | MemWrite;

    // IDLE works straight off the request inputs so a 1-cycle access needs no latched copy
    assign cur_f3    = (state_q == IDLE) ? Funct3 : f3_q;
    assign cur_addr  = (state_q == IDLE) ? Addr[AW+1:0] : addr_q;
    assign cur_wdata = (state_q == IDLE) ? WrData : wdata_q;
    assign cur_wr    = (state_q == IDLE) ? MemWrite : wr_q;
    assign cur_idx   = cur_addr[AW+1:2];

    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b1111;
        wr_lanes   = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << cur_addr[1:0];
                wr_lanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = cur_addr[0];
                byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes   = {2{cur_wdata[15:0]}};
            end
            default: misaligned = |cur_addr[1:0];
        endcase
    end

    assign word    = mem[cur_idx];
    assign shifted = word >> {cur_addr[1:0], 3'b000};

    always_comb begin
        load_val = word;
        case (cur_f3[1:0])
            2'b00:   load_val = cur_f3[2] ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = cur_f3[2] ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        Stall      = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    Stall = 1'b1;
                    if (misaligned || READ_LAT == 1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(READ_LAT - 1);
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset in the same cycle must not let an uncommitted store reach the array
    assign mem_we  = enter_done & cur_wr & ~misaligned & ~reset;
    assign rdv_d   = enter_done & ~cur_wr & ~misaligned;
    assign rdata_d = rdv_d ? load_val : 32'b0;
    assign mis_d   = enter_done & misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (state_q == IDLE && req) begin
            f3_q    <= Funct3;
            addr_q  <= Addr[AW+1:0];
            wdata_q <= WrData;
            wr_q    <= MemWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[cur_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    assign RdData      = rdata_q;
    assign RdValid     = rdv_q;
    assign MisalignErr = mis_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a byte-array reference model
module tb_dmem_responder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        mr  [2];
    logic        mw  [2];
    logic [2:0]  f3  [2];
    logic [31:0] addr[2];
    logic [31:0] wd  [2];
    logic [31:0] rdd [2];
    logic        rdv [2];
    logic        stl [2];
    logic        mis [2];

    int          total = 0;
    int          bad   = 0;
    int          lat  [2];
    int          amask[2];
    logic [7:0]  ref_b[2][4096];

    dmem_responder #(.DEPTH(1024), .READ_LAT(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .Funct3(f3[0]),
        .Addr(addr[0]), .WrData(wd[0]), .RdData(rdd[0]), .RdValid(rdv[0]),
        .Stall(stl[0]), .MisalignErr(mis[0])
    );

    dmem_responder #(.DEPTH(64), .READ_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .Funct3(f3[1]),
        .Addr(addr[1]), .WrData(wd[1]), .RdData(rdd[1]), .RdValid(rdv[1]),
        .Stall(stl[1]), .MisalignErr(mis[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] fn);
        return (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input int s, input logic [2:0] fn, input logic [31:0] a);
        int          n;
        int          base;
        logic [31:0] v;
        n    = acc_size(fn);
        base = int'(a) & amask[s];
        v    = 32'b0;
        for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(ref_b[s][base + k]);
        if (!fn[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic do_op(input int s, input logic rd, input logic wr, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        int          n;
        int          stalls;
        int          base;
        bit          misal;
        bit          exp_load;
        logic [31:0] exp_data;
        n        = acc_size(fn);
        misal    = (int'(a) % n) != 0;
        exp_load = rd && !wr && !misal;
        exp_data = exp_load ? model_load(s, fn, a) : 32'b0;
        mr[s] = rd; mw[s] = wr; f3[s] = fn; addr[s] = a; wd[s] = d;
        #1;
        stalls = 0;
        for (int c = 0; c < 20 && stl[s]; c++) begin
            stalls++;
            @(posedge clk); #1;
        end
        check("stall_cycles", 32'(stalls), misal ? 32'd1 : 32'(lat[s]));
        check("rdvalid", 32'(rdv[s]), 32'(exp_load));
        check("misalign", 32'(mis[s]), 32'(misal));
        if (exp_load || misal) check("rddata", rdd[s], exp_data);
        got = rdd[s];
        if (wr && !misal) begin
            base = int'(a) & amask[s];
            for (int k = 0; k < n; k++) ref_b[s][base + k] = d[8*k +: 8];
        end
        mr[s] = 1'b0; mw[s] = 1'b0;
        @(posedge clk); #1;
        check("rdvalid_drop", 32'(rdv[s]), 32'd0);
        check("rddata_drop", rdd[s], 32'd0);
        check("misalign_drop", 32'(mis[s]), 32'd0);
    endtask

    task automatic random_ops(input int s, input int count);
        logic [31:0] g;
        logic [2:0]  fn;
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < count; i++) begin
            kind = $urandom_range(0, 3);
            fn   = 3'($urandom_range(0, 7));
            a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_op(s, kind != 1, kind >= 1, fn, a, $urandom, g);
        end
    endtask

    logic [31:0] g;
    logic [31:0] pre30;

    initial begin
        lat[0] = 2;    lat[1] = 1;
        amask[0] = 4095; amask[1] = 255;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; mr[s] = 1'b0; mw[s] = 1'b0;
            f3[s] = 3'b0; addr[s] = 32'b0; wd[s] = 32'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_rddata", rdd[s], 32'd0);
            check("reset_rdvalid", 32'(rdv[s]), 32'd0);
            check("reset_stall", 32'(stl[s]), 32'd0);
            check("reset_misalign", 32'(mis[s]), 32'd0);
            rst[s] = 1'b0;
        end

        // seed a known window so every later load has a defined expectation
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++) do_op(s, 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, g);

        do_op(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, g);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, g);  check("lw_10", g, 32'hDEAD_BEEF);
        do_op(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, g);  check("lb_13", g, 32'hFFFF_FFDE);
        do_op(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, g);  check("lbu_13", g, 32'h0000_00DE);
        do_op(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, g);  check("lh_12", g, 32'hFFFF_DEAD);
        do_op(0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, g);  check("lhu_10", g, 32'h0000_BEEF);
        do_op(0, 1'b0, 1'b1, 3'b000, 32'h11, 32'h55, g);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, g);  check("sb_11", g, 32'hDEAD_55EF);
        do_op(0, 1'b0, 1'b1, 3'b001, 32'h12, 32'h1234, g);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, g);  check("sh_12", g, 32'h1234_55EF);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h0E, 32'h0, g);
        do_op(0, 1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF, g);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, g);  check("sh_mis_nowrite", g, 32'h1234_55EF);
        do_op(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5, g);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, g);  check("both_is_store", g, 32'hA5A5_A5A5);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h10 + 32'd4096, 32'h0, g);  check("alias_10", g, 32'h1234_55EF);
        do_op(0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, g);  check("f3_011_as_w", g, 32'h1234_55EF);

        // reset while the store is in BUSY must discard it
        pre30 = model_load(0, 3'b010, 32'h30);
        mr[0] = 1'b0; mw[0] = 1'b1; f3[0] = 3'b010; addr[0] = 32'h30; wd[0] = 32'h1;
        #1;
        check("rst_req_stall", 32'(stl[0]), 32'd1);
        @(posedge clk); #1;
        check("rst_busy_stall", 32'(stl[0]), 32'd1);
        rst[0] = 1'b1; mw[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("rst_mid_stall", 32'(stl[0]), 32'd0);
        check("rst_mid_rdvalid", 32'(rdv[0]), 32'd0);
        check("rst_mid_rddata", rdd[0], 32'd0);
        check("rst_mid_misalign", 32'(mis[0]), 32'd0);
        do_op(0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, g);  check("rst_store_dropped", g, pre30);

        do_op(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, g);
        do_op(1, 1'b1, 1'b0, 3'b010, 32'h10 + 32'd256, 32'h0, g);  check("lat1_alias", g, 32'hCAFE_F00D);
        do_op(1, 1'b1, 1'b0, 3'b001, 32'h13, 32'h0, g);

        random_ops(0, 150);
        random_ops(1, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
